// File: rtl/enc_event_pkg.sv
// Shared types and constants for the priority-encoder event path.
package enc_event_pkg;

    localparam int CODE_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMING = 2'd1,
        HELD   = 2'd2
    } smp_state_e;

endpackage

// File: rtl/code_fifo.sv
// Synchronous FIFO with a registered occupancy count and no read fall-through.
module code_fifo #(
    parameter int DEPTH  = 4,
    parameter int CODE_W = 3,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [CODE_W-1:0] din,
    output logic [CODE_W-1:0] dout,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);

    logic [CODE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr, rptr;
    logic              do_push, do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    assign dout = mem[rptr];

endmodule

// File: rtl/enc_event_fifo.sv
// Debounces the encoder index and queues one event per stable code.
module enc_event_fifo
    import enc_event_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STABLE_CYC = 3,
    parameter int CODE_W     = enc_event_pkg::CODE_W,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_idc,
    input  logic [CODE_W-1:0] in_y,
    output logic              out_valid,
    output logic [CODE_W-1:0] out_code,
    input  logic              out_ready,
    output logic [CW-1:0]     count,
    output logic              overflow
);

    localparam logic [7:0] LAST_CNT = 8'(STABLE_CYC - 1);

    smp_state_e        state_q, state_d;
    logic [CODE_W-1:0] cand_q, cand_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              push;

    logic [CODE_W-1:0] fifo_dout;
    logic              fifo_full, fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_idc) begin
                    state_d = ARMING;
                    cand_d  = in_y;
                    cnt_d   = 8'd1;
                end
            end
            ARMING: begin
                if (!in_idc) begin
                    state_d = IDLE;
                end else if (in_y != cand_q) begin
                    cand_d = in_y;
                    cnt_d  = 8'd1;
                end else if (cnt_q == LAST_CNT) begin
                    push    = 1'b1;
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HELD: begin
                if (!in_idc) begin
                    state_d = IDLE;
                end else if (in_y != cand_q) begin
                    state_d = ARMING;
                    cand_d  = in_y;
                    cnt_d   = 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    code_fifo #(
        .DEPTH  (DEPTH),
        .CODE_W (CODE_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (out_ready),
        .din   (cand_q),
        .dout  (fifo_dout),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The FSM still goes to HELD on a dropped push, so the loss is only visible here.
    always_ff @(posedge clk) begin
        if (rst)
            overflow <= 1'b0;
        else if (push && fifo_full && !out_ready)
            overflow <= 1'b1;
    end

    assign out_valid = !fifo_empty;
    assign out_code  = fifo_empty ? '0 : fifo_dout;

endmodule

// File: tb/tb_enc_event_fifo.sv
// Scoreboard bench for enc_event_fifo: a run-length debounce model feeds an expected queue.
module tb_enc_event_fifo;

    localparam int DEPTH      = 4;
    localparam int STABLE_CYC = 3;
    localparam int CODE_W     = 3;
    localparam int CW         = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              in_idc;
    logic [CODE_W-1:0] in_y;
    logic              out_valid;
    logic [CODE_W-1:0] out_code;
    logic              out_ready;
    logic [CW-1:0]     count;
    logic              overflow;

    enc_event_fifo #(
        .DEPTH      (DEPTH),
        .STABLE_CYC (STABLE_CYC),
        .CODE_W     (CODE_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_idc    (in_idc),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_code  (out_code),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [CODE_W-1:0] exp_q [$];
    int                run     = 0;
    logic [CODE_W-1:0] last    = '0;
    logic              exp_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive, let the edge happen, advance the model, compare all outputs.
    task automatic step(input logic r, input logic idc, input logic [CODE_W-1:0] y, input logic rdy);
        logic pop, psh;
        rst = r; in_idc = idc; in_y = y; out_ready = rdy;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            run     = 0;
            exp_ovf = 1'b0;
        end else begin
            pop = (exp_q.size() > 0) && rdy;
            if (!idc)                       run = 0;
            else if (run > 0 && y == last)  run++;
            else begin run = 1; last = y; end
            psh = idc && (run == STABLE_CYC);
            if (pop) void'(exp_q.pop_front());
            if (psh) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(y);
                else                      exp_ovf = 1'b1;
            end
        end
        #1;
        chk("out_valid", out_valid, exp_q.size() > 0);
        chk("out_code",  out_code,  exp_q.size() > 0 ? exp_q[0] : '0);
        chk("count",     count,     exp_q.size());
        chk("overflow",  overflow,  exp_ovf);
    endtask

    task automatic hold(input logic idc, input logic [CODE_W-1:0] y, input logic rdy, input int n);
        for (int i = 0; i < n; i++) step(1'b0, idc, y, rdy);
    endtask

    initial begin
        rst = 1'b1; in_idc = 1'b0; in_y = '0; out_ready = 1'b0;

        // Reset with an active request, then confirm the full stability count is needed.
        step(1'b1, 1'b1, 3'd7, 1'b1);
        step(1'b1, 1'b1, 3'd7, 1'b1);
        hold(1'b1, 3'd7, 1'b0, STABLE_CYC - 1);
        chk("t1_no_early_push", count, 0);
        hold(1'b1, 3'd7, 1'b0, 1);
        chk("t1_push_after_count", count, 1);
        step(1'b1, 1'b0, 3'd0, 1'b0);

        // Single acceptance held for 10 cycles.
        hold(1'b1, 3'd5, 1'b0, 2);
        chk("t2_not_yet_valid", out_valid, 0);
        hold(1'b1, 3'd5, 1'b0, 1);
        chk("t2_valid_c3", out_valid, 1);
        hold(1'b1, 3'd5, 1'b0, 7);
        chk("t2_single_push", count, 1);
        chk("t2_code", out_code, 5);
        step(1'b1, 1'b0, 3'd0, 1'b0);

        // Glitch rejection.
        hold(1'b1, 3'd2, 1'b0, 2);
        hold(1'b1, 3'd6, 1'b0, 3);
        hold(1'b0, 3'd0, 1'b0, 2);
        chk("t3_count", count, 1);
        chk("t3_code", out_code, 6);
        step(1'b1, 1'b0, 3'd0, 1'b0);

        // Ordering and re-push of the same code after a drop.
        hold(1'b1, 3'd1, 1'b0, 4); hold(1'b0, 3'd0, 1'b0, 1);
        hold(1'b1, 3'd3, 1'b0, 4); hold(1'b0, 3'd0, 1'b0, 1);
        hold(1'b1, 3'd1, 1'b0, 4); hold(1'b0, 3'd0, 1'b0, 1);
        chk("t4_count", count, 3);
        hold(1'b0, 3'd0, 1'b1, 4);
        chk("t4_drained", out_valid, 0);
        step(1'b1, 1'b0, 3'd0, 1'b0);

        // Overflow: fifth accepted code is dropped.
        for (int c = 0; c < 5; c++) begin
            hold(1'b1, 3'(c), 1'b0, STABLE_CYC);
            hold(1'b0, 3'd0, 1'b0, 1);
        end
        chk("t5_count", count, 4);
        chk("t5_overflow", overflow, 1);
        chk("t5_head", out_code, 0);
        hold(1'b0, 3'd0, 1'b1, 5);
        step(1'b1, 1'b0, 3'd0, 1'b0);

        // Full FIFO with push and pop on the same edge.
        for (int c = 0; c < 4; c++) begin
            hold(1'b1, 3'(c), 1'b0, STABLE_CYC);
            hold(1'b0, 3'd0, 1'b0, 1);
        end
        hold(1'b1, 3'd7, 1'b0, STABLE_CYC - 1);
        step(1'b0, 1'b1, 3'd7, 1'b1);
        chk("t6_count_full", count, 4);
        chk("t6_overflow", overflow, 0);
        chk("t6_head", out_code, 1);
        hold(1'b0, 3'd0, 1'b0, 1);
        hold(1'b0, 3'd0, 1'b1, 3);
        chk("t6_tail", out_code, 7);
        hold(1'b0, 3'd0, 1'b0, 1);
        // Reset while arming.
        hold(1'b1, 3'd5, 1'b0, STABLE_CYC - 1);
        step(1'b1, 1'b1, 3'd5, 1'b0);
        chk("t6_rst_empty", out_valid, 0);
        hold(1'b1, 3'd5, 1'b0, STABLE_CYC - 1);
        hold(1'b0, 3'd0, 1'b0, 2);
        chk("t6_no_push_after_rst", count, 0);

        // Random traffic against the model.
        begin
            logic [CODE_W-1:0] y = 3'd0;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 3) == 0) y = 3'($urandom_range(0, 7));
                step($urandom_range(0, 99) == 0, $urandom_range(0, 4) != 0, y,
                     $urandom_range(0, 3) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
